// File: rtl/adder_32b_gl_pkg.sv
// Shared widths for the gate-level ripple-carry adder.
// The 32-bit result is built from 4-bit slices chained through their carries.
package adder_32b_gl_pkg;

  localparam int ADDER_NBITS    = 32;
  localparam int ADDER_BLK_BITS = 4;
  localparam int ADDER_NBLKS    = ADDER_NBITS / ADDER_BLK_BITS;

endpackage : adder_32b_gl_pkg

// File: rtl/adder_4b_gl.sv
// Four-bit ripple-carry slice: four full adders with carry in and carry out.
module adder_4b_gl
  import adder_32b_gl_pkg::*;
(
  input  logic [ADDER_BLK_BITS-1:0] i_a,
  input  logic [ADDER_BLK_BITS-1:0] i_b,
  input  logic                      i_cin,
  output logic [ADDER_BLK_BITS-1:0] o_sum,
  output logic                      o_cout
);

  logic [ADDER_BLK_BITS:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar gi = 0; gi < ADDER_BLK_BITS; gi++) begin : g_bit
    full_adder_gl u_fa (
      .a    (i_a[gi]),
      .b    (i_b[gi]),
      .cin  (w_carry[gi]),
      .sum  (o_sum[gi]),
      .cout (w_carry[gi+1])
    );
  end

  assign o_cout = w_carry[ADDER_BLK_BITS];

endmodule : adder_4b_gl

// File: rtl/full_adder_gl.sv
// One-bit full adder from single-operator gate assigns.
// The a^b term is shared between the sum and the propagate side of the carry.
module full_adder_gl (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_axb;
  logic w_gen;
  logic w_prop;

  assign w_axb  = a ^ b;
  assign sum    = w_axb ^ cin;
  assign w_gen  = a & b;
  assign w_prop = cin & w_axb;
  assign cout   = w_gen | w_prop;

endmodule : full_adder_gl

// File: rtl/adder_32b_gl.sv
// Unsigned 32-bit adder, result modulo 2^32, as eight chained 4-bit ripple slices.
// clk and reset only exist for interface uniformity with the rest of the datapath.
module adder_32b_gl
  import adder_32b_gl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDER_NBITS-1:0] in0,
  input  logic [ADDER_NBITS-1:0] in1,
  output logic [ADDER_NBITS-1:0] sum
);

  logic [ADDER_NBLKS:0] w_carry;

  assign w_carry[0] = 1'b0;

  for (genvar gb = 0; gb < ADDER_NBLKS; gb++) begin : g_blk
    adder_4b_gl u_blk (
      .i_a    (in0[gb*ADDER_BLK_BITS +: ADDER_BLK_BITS]),
      .i_b    (in1[gb*ADDER_BLK_BITS +: ADDER_BLK_BITS]),
      .i_cin  (w_carry[gb]),
      .o_sum  (sum[gb*ADDER_BLK_BITS +: ADDER_BLK_BITS]),
      .o_cout (w_carry[gb+1])
    );
  end

  // Carry out of bit 31 is dropped (modulo-2^32 result); clk/reset are unused.
  logic w_unused;
  assign w_unused = &{1'b0, clk, reset, w_carry[ADDER_NBLKS]};

endmodule : adder_32b_gl

// File: tb/tb_adder_32b_gl.sv
// Directed and seeded-random checks of the 32-bit gate-level adder,
// including wrap-around cases and operation with reset held low.
module tb_adder_32b_gl;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [31:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_32b_gl dut (
    .clk   (clk),
    .reset (reset),
    .in0   (in0),
    .in1   (in1),
    .sum   (sum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive_and_check(input string tag, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp);
    @(posedge clk);
    #1;
    in0 = a;
    in1 = b;
    #8;
    chk(tag, sum, exp);
  endtask

  vec_t dir [14] = '{
    '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000},
    '{32'h0000_0000, 32'h0000_0001, 32'h0000_0001},
    '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001},
    '{32'h0000_0001, 32'h0000_0001, 32'h0000_0002},
    '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
    '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000},
    '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000},
    '{32'h1234_5678, 32'h8765_4321, 32'h9999_9999},
    '{32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF},
    '{32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100},
    '{32'h0F0F_0F0F, 32'h0101_0101, 32'h1010_1010}
  };

  logic [31:0] rnd_a [16];
  logic [31:0] rnd_b [16];

  initial begin
    logic [31:0] exp_s;
    reset = 1'b0;
    in0   = '0;
    in1   = '0;

    // Reset low: the adder must still track its inputs.
    drive_and_check("rst_low_zero", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    drive_and_check("rst_low_carry", 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    drive_and_check("rst_low_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);

    reset = 1'b1;
    for (int i = 0; i < 14; i++)
      drive_and_check($sformatf("dir%0d", i), dir[i].a, dir[i].b, dir[i].s);

    void'($urandom(32'd20240611));
    for (int i = 0; i < 16; i++) begin
      rnd_a[i] = $urandom;
      rnd_b[i] = $urandom;
      exp_s    = rnd_a[i] + rnd_b[i];
      drive_and_check($sformatf("rnd%0d", i), rnd_a[i], rnd_b[i], exp_s);
    end

    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_s = rnd_a[i] + rnd_b[i];
      drive_and_check($sformatf("rnd_rst%0d", i), rnd_a[i], rnd_b[i], exp_s);
    end
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_adder_32b_gl
